// File: rtl/hrange2d.sv
// hrange2d: nested signed range generator emitting (i, j) row-major, one pair per cycle.
// Optional HRANGE2D_COUNT_EN adds _count, the number of pairs emitted since the last _start.
module hrange2d #(
  parameter int WIDTH = 32
`ifdef HRANGE2D_COUNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic             _wait,
  input  logic [WIDTH-1:0] base0,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] step0,
  input  logic [WIDTH-1:0] base1,
  input  logic [WIDTH-1:0] limit1,
  input  logic [WIDTH-1:0] step1,
  output logic [WIDTH-1:0] _0,
  output logic [WIDTH-1:0] _1,
  output logic             _valid,
  output logic             _ready
`ifdef HRANGE2D_COUNT_EN
  , output logic [CNT_W-1:0] _count
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] i, j, i_n, j_n, b1, l0, s0, l1, s1, o0_n, o1_n;
  logic [WIDTH:0] jn, inx;
  logic v_n, r_n;
  function automatic logic empty_r(input logic [WIDTH-1:0] b, l, s);
    return s == '0 || (s[WIDTH-1] ? $signed(b) <= $signed(l) : $signed(b) >= $signed(l));
  endfunction
  // Compare one bit wider so a wrapped sum can never look like it is still in range.
  function automatic logic in_r(input logic [WIDTH:0] n, input logic [WIDTH-1:0] l, input logic neg);
    return neg ? $signed(n) > $signed({l[WIDTH-1], l}) : $signed(n) < $signed({l[WIDTH-1], l});
  endfunction
  assign jn = {j[WIDTH-1], j} + {s1[WIDTH-1], s1};
  assign inx = {i[WIDTH-1], i} + {s0[WIDTH-1], s0};
  always_comb begin
    state_n = state;
    i_n = i;
    j_n = j;
    v_n = 1'b0;
    r_n = 1'b0;
    o0_n = '0;
    o1_n = '0;
    if (_start) begin
      if (empty_r(base0, limit0, step0) || empty_r(base1, limit1, step1)) begin
        r_n = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = RUN;
        i_n = base0;
        j_n = base1;
        v_n = 1'b1;
        o0_n = base0;
        o1_n = base1;
      end
    end else if (state == RUN) begin
      if (in_r(jn, l1, s1[WIDTH-1])) begin
        j_n = jn[WIDTH-1:0];
        v_n = 1'b1;
        o0_n = i;
        o1_n = jn[WIDTH-1:0];
      end else if (in_r(inx, l0, s0[WIDTH-1])) begin
        i_n = inx[WIDTH-1:0];
        j_n = b1;
        v_n = 1'b1;
        o0_n = inx[WIDTH-1:0];
        o1_n = b1;
      end else begin
        r_n = 1'b1;
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      b1 <= '0;
      l0 <= '0;
      s0 <= '0;
      l1 <= '0;
      s1 <= '0;
      _0 <= '0;
      _1 <= '0;
      _valid <= 1'b0;
      _ready <= 1'b0;
    end else if (_wait) begin
      _0 <= '0;
      _1 <= '0;
      _valid <= 1'b0;
      _ready <= 1'b0;
    end else begin
      state <= state_n;
      i <= i_n;
      j <= j_n;
      _0 <= o0_n;
      _1 <= o1_n;
      _valid <= v_n;
      _ready <= r_n;
      if (_start) begin
        b1 <= base1;
        l0 <= limit0;
        s0 <= step0;
        l1 <= limit1;
        s1 <= step1;
      end
    end
  end
`ifdef HRANGE2D_COUNT_EN
  always_ff @(posedge _clock) begin
    if (_reset) _count <= '0;
    else if (!_wait) _count <= _start ? CNT_W'(v_n) : _count + CNT_W'(v_n);
  end
`endif
endmodule
